// File: rtl/image_ctrl_pkg.sv
// Shared types and constants for the multi-drive SD image controller.
package image_ctrl_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned SECT_AW      = 9;

    typedef enum logic [3:0] {
        StIdle,
        StSetup,
        StRdCapt,
        StRdStb,
        StRdNext,
        StWrFetch,
        StWrLatch,
        StWrStb,
        StWrNext,
        StDone,
        StRelease
    } state_t;

    // Drive-index width; a single drive needs no index bits.
    function automatic int unsigned drv_w(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

endpackage

// File: rtl/image_ctrl_arb.sv
// Fixed-priority request arbiter: lowest drive index wins, read beats write.
module image_ctrl_arb #(
    parameter int unsigned NUM_DRIVES = 2,
    parameter int unsigned IDX_W      = 1
) (
    input  logic [NUM_DRIVES-1:0] rd,
    input  logic [NUM_DRIVES-1:0] wr,
    output logic [IDX_W-1:0]      grant,
    output logic                  valid,
    output logic                  is_read
);

    always_comb begin
        grant   = '0;
        valid   = 1'b0;
        is_read = 1'b0;
        // Scan downwards so the lowest requesting index is the last one written.
        for (int i = int'(NUM_DRIVES) - 1; i >= 0; i--) begin
            if (rd[i] || wr[i]) begin
                grant   = IDX_W'(i);
                valid   = 1'b1;
                is_read = rd[i];
            end
        end
    end

endmodule

// File: rtl/image_controller_mc.sv
// Multi-drive sector mover between the SD sector buffer and the shared image SRAM.
module image_controller_mc
    import image_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DRIVES = 2,
    parameter int unsigned SRAM_AW    = 20
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [31:0]           sd_lba,
    input  logic [NUM_DRIVES-1:0] sd_rd,
    input  logic [NUM_DRIVES-1:0] sd_wr,
    input  logic [NUM_DRIVES-1:0] wp_i,
    output logic [NUM_DRIVES-1:0] sd_ack,
    output logic [SECT_AW-1:0]    sd_buff_addr,
    output logic [7:0]            sd_buff_dout,
    input  logic [7:0]            sd_buff_din,
    output logic                  sd_buff_wr,
    output logic [SRAM_AW-1:0]    sram_addr_o,
    input  logic [7:0]            sram_data_i,
    output logic [7:0]            sram_data_o,
    output logic                  sram_we_o,
    output logic                  busy_o
);

    localparam int unsigned DRV_W  = drv_w(NUM_DRIVES);
    localparam int unsigned DRV_SW = (DRV_W == 0) ? 1 : DRV_W;
    localparam int unsigned LBA_W  = SRAM_AW - SECT_AW - DRV_W;
    localparam logic [SECT_AW-1:0] LAST_BYTE = SECT_AW'(SECTOR_BYTES - 1);

    state_t               state_q, state_d;
    logic [DRV_SW-1:0]    drv_q;
    logic                 rd_q;
    logic [LBA_W-1:0]     lba_q;
    logic                 oor_q;
    logic                 sup_q;
    logic [SECT_AW-1:0]   byte_q;
    logic [7:0]           dout_q;
    logic [7:0]           wdata_q;

    logic [DRV_SW-1:0]    arb_grant;
    logic                 arb_valid;
    logic                 arb_read;
    logic                 lba_oor;
    logic                 last_byte;

    image_ctrl_arb #(
        .NUM_DRIVES (NUM_DRIVES),
        .IDX_W      (DRV_SW)
    ) u_arb (
        .rd      (sd_rd),
        .wr      (sd_wr),
        .grant   (arb_grant),
        .valid   (arb_valid),
        .is_read (arb_read)
    );

    assign lba_oor   = |(sd_lba >> LBA_W);
    assign last_byte = (byte_q == LAST_BYTE);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (arb_valid) state_d = StSetup;
            StSetup:   state_d = rd_q ? StRdCapt : StWrFetch;
            StRdCapt:  state_d = StRdStb;
            StRdStb:   state_d = StRdNext;
            StRdNext:  state_d = last_byte ? StDone : StRdCapt;
            StWrFetch: state_d = StWrLatch;
            StWrLatch: state_d = StWrStb;
            StWrStb:   state_d = StWrNext;
            StWrNext:  state_d = last_byte ? StDone : StWrFetch;
            StDone:    state_d = StRelease;
            // Hold off until the served drive's level request is gone.
            StRelease: if (!sd_rd[drv_q] && !sd_wr[drv_q]) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        sd_ack     = '0;
        busy_o     = (state_q != StIdle);
        sd_buff_wr = (state_q == StRdStb);
        sram_we_o  = (state_q == StWrStb) && !sup_q;
        if (state_q != StIdle && state_q != StRelease) begin
            sd_ack[drv_q] = 1'b1;
        end
    end

    // Transfer datapath
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drv_q   <= '0;
            rd_q    <= 1'b0;
            lba_q   <= '0;
            oor_q   <= 1'b0;
            sup_q   <= 1'b0;
            byte_q  <= '0;
            dout_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        drv_q  <= arb_grant;
                        rd_q   <= arb_read;
                        lba_q  <= sd_lba[LBA_W-1:0];
                        oor_q  <= lba_oor;
                        byte_q <= '0;
                    end
                end
                StSetup:   sup_q  <= oor_q || wp_i[drv_q];
                StRdCapt:  dout_q <= oor_q ? 8'hFF : sram_data_i;
                StWrLatch: wdata_q <= sd_buff_din;
                StRdNext, StWrNext: begin
                    if (!last_byte) byte_q <= byte_q + SECT_AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign sd_buff_addr = byte_q;
    assign sd_buff_dout = dout_q;
    assign sram_data_o  = wdata_q;

    if (DRV_W > 0) begin : g_addr_drv
        assign sram_addr_o = {drv_q[DRV_SW-1:0], lba_q, byte_q};
    end else begin : g_addr_nodrv
        assign sram_addr_o = {lba_q, byte_q};
    end

endmodule
